conc_stim_player: RTL
=====================

// Module: conc_stim_player
// PURPOSE
//  Synthesizable vector player that sits directly upstream of the b06 DUT and drives its
//  inputs {__obs, cont_eql, eql} from a loaded opcode memory, one vector per clock.
//  Replaces the behavioural $readmemb/program-counter stimulus so the same vector stream
//  can run on emulation or FPGA. The issued-vector count is exported for the concolic trace.
// PARAMETERS
//  VEC_W   3     width of one stimulus vector; bit2=__obs, bit1=cont_eql, bit0=eql
//  DEPTH   1011  vector memory depth (words)
//  ADDR_W  10    address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clock     in   1       single clock, rising edge
//  reset     in   1       synchronous, active-high
//  clear     in   1       zero the fill count (IDLE only; ignored otherwise)
//  ld_valid  in   1       load word present
//  ld_ready  out  1       load word accepted this cycle when ld_valid=1
//  ld_data   in   VEC_W   vector to append at address fill_cnt
//  start     in   1       begin playback from address 0
//  stop      in   1       abort playback, return to IDLE
//  vec_out   out  VEC_W   vector driven onto DUT inputs
//  vec_valid out  1       vec_out carries a freshly issued vector this cycle
//  pc        out  32      number of vectors issued since last start
//  busy      out  1       state==RUN
//  done      out  1       state==DONE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, fill_cnt=0, vec_out=0, vec_valid=0, pc=0,
//    busy=0, done=0, ld_ready=0 during the reset cycle; memory contents left unspecified.
//  - States: IDLE, RUN, DONE.
//  - IDLE: ld_ready = (fill_cnt < DEPTH). On ld_valid&&ld_ready: mem[fill_cnt]<=ld_data,
//    fill_cnt++. clear zeroes fill_cnt; clear with ld_valid in the same cycle: clear wins,
//    no write.
//  - start in IDLE or DONE with fill_cnt>0 -> RUN, rd_addr=0, pc=0. start with fill_cnt=0
//    is ignored (stays in current state).
//  - RUN: each cycle read mem[rd_addr]; vec_out<=that word one cycle later (1-cycle latency
//    from entering RUN to the first vec_valid); pc increments on every vec_valid cycle.
//    rd_addr==fill_cnt-1 is the final read: -> DONE after its vector is issued.
//  - Last vector: vec_out holds it in DONE, vec_valid=0, pc holds final count (=fill_cnt).
//  - stop in RUN: -> IDLE next cycle; vec_out=0, vec_valid=0; pc holds. stop and start in
//    the same cycle: stop wins. stop in DONE -> IDLE, vec_out=0.
//  - ld_ready=0 in RUN and DONE; loads are only accepted in IDLE.
//  - pc is 32-bit, wraps modulo 2**32 (only reachable with STIM_LOOP_EN).
//  - Reset mid-RUN: aborts immediately to reset values; fill_cnt cleared, so reload needed.
// CONFIGURATION
//  STIM_LOOP_EN defined: after the final address RUN continues at address 0 without a
//    bubble (vec_valid stays 1), pc keeps counting, DONE never entered; only stop/reset exit.
//  STIM_LOOP_EN undefined: single pass, RUN -> DONE as above.
// STRUCTURE
//  - conc_stim_pkg: state enum (IDLE/RUN/DONE), VEC_W default, bit-index constants
//    OBS_BIT=2, CONT_EQL_BIT=1, EQL_BIT=0.
//  - One sub-module conc_stim_ram: single-port synchronous RAM DEPTH x VEC_W; write in IDLE,
//    read in RUN (the two are exclusive, no port conflict).
//  - Top holds the FSM, fill_cnt, rd_addr, pc and output registers.
// TESTING
//  1 Load 3'b001,3'b010,3'b100, start -> vec_valid 3 cycles starting 1 cycle after RUN, vec_out
//    001,010,100, then DONE, pc=3, vec_out holds 100.
//  2 Load DEPTH words with ld_valid held -> ld_ready drops after word 1011; word 1012 not
//    written, fill_cnt=1011.
//  3 Start with empty memory -> stays IDLE, busy=0, vec_valid never asserted.
//  4 Load 5 words, start, stop after 2 issued -> IDLE next cycle, vec_out=0, pc=2; start
//    again -> replays from word 0, pc restarts at 0.
//  5 Assert reset mid-RUN -> next cycle all outputs at reset values, ld_ready=1 after reset
//    deasserts, fill_cnt=0.
//  6 With STIM_LOOP_EN, load 2 words 011,110, start -> continuous 011,110,011,... no gaps,
//    pc=6 after 6 vectors, done never 1.

Source files
------------

// File: rtl/conc_stim_pkg.sv
// Shared types and constants for the stimulus vector player that drives the b06 inputs.
// Vector bit layout: bit2=__obs, bit1=cont_eql, bit0=eql.
package conc_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int VEC_W_DEF    = 3;
    localparam int OBS_BIT      = 2;
    localparam int CONT_EQL_BIT = 1;
    localparam int EQL_BIT      = 0;

endpackage

// File: rtl/conc_stim_ram.sv
// Single-port synchronous vector store: written while loading, read while playing.
// Read data is registered and only updates on a read access.
module conc_stim_ram #(
    parameter int VEC_W  = 3,
    parameter int DEPTH  = 1011,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [VEC_W-1:0]  wdata,
    output logic [VEC_W-1:0]  rdata
);

    logic [VEC_W-1:0] mem [DEPTH];
    logic [VEC_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conc_stim_player.sv
// Vector player: loads stimulus words in IDLE, replays them one per clock in RUN.
// Define STIM_LOOP_EN to replay continuously instead of a single pass ending in DONE.
module conc_stim_player
    import conc_stim_pkg::*;
#(
    parameter int VEC_W  = VEC_W_DEF,
    parameter int DEPTH  = 1011,
    parameter int ADDR_W = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [VEC_W-1:0] ld_data,
    input  logic             start,
    input  logic             stop,
    output logic [VEC_W-1:0] vec_out,
    output logic             vec_valid,
    output logic [31:0]      pc,
    output logic             busy,
    output logic             done
);

    // One extra bit so a completely full memory (fill == DEPTH) is representable.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              last_q, last_d;
    logic [VEC_W-1:0]  vec_out_q, vec_out_d;
    logic              vec_valid_q, vec_valid_d;
    logic [31:0]       pc_q, pc_d;
    logic              ld_ready_q, ld_ready_d;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [VEC_W-1:0]  ram_rdata;
    logic              go_run, can_start, at_last;

    conc_stim_ram #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ld_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rd_addr_d   = rd_addr_q;
        last_d      = last_q;
        vec_out_d   = vec_out_q;
        vec_valid_d = 1'b0;
        pc_d        = pc_q;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = rd_addr_q;
        go_run      = 1'b0;
        can_start   = start && (fill_q != '0);
        at_last     = ({1'b0, rd_addr_q} == (fill_q - CNT_W'(1)));

        unique case (state_q)
            ST_IDLE: begin
                if (!stop && can_start) begin
                    go_run = 1'b1;
                end else if (clear) begin
                    fill_d = '0;
                end else if (ld_valid && ld_ready_q) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = fill_q[ADDR_W-1:0];
                    fill_d   = fill_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    vec_out_d = '0;
                end else if (last_q) begin
                    state_d = ST_DONE;
                end else begin
                    // Issue the word read last cycle while fetching the next one.
                    vec_out_d   = ram_rdata;
                    vec_valid_d = 1'b1;
                    pc_d        = pc_q + 32'd1;
                    if (at_last) begin
`ifdef STIM_LOOP_EN
                        rd_addr_d = '0;
                        ram_en    = 1'b1;
                        ram_addr  = '0;
`else
                        last_d = 1'b1;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        ram_en    = 1'b1;
                        ram_addr  = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    vec_out_d = '0;
                end else if (can_start) begin
                    go_run = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                vec_out_d = '0;
            end
        endcase

        if (go_run) begin
            state_d   = ST_RUN;
            rd_addr_d = '0;
            last_d    = 1'b0;
            pc_d      = '0;
            ram_en    = 1'b1;
            ram_addr  = '0;
        end

        ld_ready_d = (state_d == ST_IDLE) && (fill_d < DEPTH_C);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            rd_addr_q   <= '0;
            last_q      <= 1'b0;
            vec_out_q   <= '0;
            vec_valid_q <= 1'b0;
            pc_q        <= '0;
            ld_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rd_addr_q   <= rd_addr_d;
            last_q      <= last_d;
            vec_out_q   <= vec_out_d;
            vec_valid_q <= vec_valid_d;
            pc_q        <= pc_d;
            ld_ready_q  <= ld_ready_d;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign vec_out   = vec_out_q;
    assign vec_valid = vec_valid_q;
    assign pc        = pc_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule
